// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: mode and direction encodings,
// plus the pattern each mode starts from.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    localparam int        LED_W       = 8;
    localparam logic [7:0] INIT_ROT_L  = 8'h01;
    localparam logic [7:0] INIT_ROT_R  = 8'h80;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_FILL   = 8'h01;

    function automatic logic [7:0] init_pattern(input mode_e m);
        logic [7:0] p;
        p = INIT_ROT_L;
        case (m)
            MODE_ROT_L:  p = INIT_ROT_L;
            MODE_ROT_R:  p = INIT_ROT_R;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_FILL:   p = INIT_FILL;
            default:     p = INIT_ROT_L;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the board switches and the LED sequencer.
// master drives the switches side, slave is the sequencer itself.
interface led_seq_ctrl_if #(parameter int W = 8);

    logic         en;
    logic         mode_req;
    logic [1:0]   mode;
    logic [W-1:0] led;
    logic         step;
    logic         mode_ack;
    logic [1:0]   cur_mode;

    modport master (
        output en, mode_req, mode,
        input  led, step, mode_ack, cur_mode
    );

    modport slave (
        input  en, mode_req, mode,
        output led, step, mode_ack, cur_mode
    );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler producing one step tick every DIV enabled clock cycles.
// clr restarts the count so a freshly loaded pattern gets a full step period.
module led_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: steps the selected display pattern once per prescaler
// tick; a mode request reloads the pattern immediately and restarts the tick.
//
// state (cur_mode) | meaning
// -----------------+----------------------------------------------
// MODE_ROT_L       | single lit LED rotating left, 80 -> 01
// MODE_ROT_R       | single lit LED rotating right, 01 -> 80
// MODE_BOUNCE      | single lit LED bouncing between bit 0 and bit 7
// MODE_FILL        | bar filling from bit 0 up to FF, then 00, then 01
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int DIV = 4,
    parameter int W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    led_seq_ctrl_if.slave  bus
);

    localparam logic [W-1:0] ONE_HOT_LO = W'(1);
    localparam logic [W-1:0] ALL_ON     = '1;

    mode_e        mode_q, mode_d;
    dir_e         dir_q,  dir_d;
    logic [W-1:0] led_q,  led_d;
    logic         step_q, step_d;
    logic         ack_q,  ack_d;
    logic         tick;

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.mode_req),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_ROT_L;
            dir_q  <= LEFT;
            led_q  <= W'(INIT_ROT_L);
            step_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
            ack_q  <= ack_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = 1'b0;
        ack_d  = 1'b0;

        // A request wins over a coincident tick; that tick is simply lost.
        if (bus.mode_req) begin
            mode_d = mode_e'(bus.mode);
            led_d  = W'(init_pattern(mode_e'(bus.mode)));
            dir_d  = LEFT;
            ack_d  = 1'b1;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_ROT_L: led_d = {led_q[W-2:0], led_q[W-1]};
                MODE_ROT_R: led_d = {led_q[0], led_q[W-1:1]};
                MODE_BOUNCE: begin
                    // Direction turns at the ends, so each end is shown only once.
                    if (dir_q == LEFT) begin
                        if (led_q[W-1]) begin
                            led_d = led_q >> 1;
                            dir_d = RIGHT;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = led_q << 1;
                            dir_d = LEFT;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_FILL: begin
                    if (led_q == ALL_ON)
                        led_d = '0;
                    else if (led_q == '0)
                        led_d = ONE_HOT_LO;
                    else
                        led_d = {led_q[W-2:0], 1'b1};
                end
                default: led_d = led_q;
            endcase
        end
    end

    assign bus.led      = led_q;
    assign bus.step     = step_q;
    assign bus.mode_ack = ack_q;
    assign bus.cur_mode = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DIV=4: reset, every mode's sequence,
// enable freeze, tick/request collision, back-to-back requests, reset priority.
module tb_led_seq_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    led_seq_ctrl_if #(.W(8)) bus ();

    led_seq_ctrl #(
        .DIV (4),
        .W   (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Three quiet cycles, then the step pulse with the new pattern.
    task automatic run_tick(input string tag, input logic [7:0] exp_led);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check({tag, "_idle_step"}, 8'(bus.step), 8'h00);
        end
        cycle(1);
        check({tag, "_step"}, 8'(bus.step), 8'h01);
        check({tag, "_led"}, bus.led, exp_led);
    endtask

    task automatic request(input logic [1:0] m);
        bus.mode_req = 1'b1;
        bus.mode     = m;
        cycle(1);
        bus.mode_req = 1'b0;
    endtask

    logic [7:0] rotl_seq   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_seq   [9]  = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.mode_req = 1'b0;
        bus.mode     = 2'd0;
        cycle(2);
        check("rst_led", bus.led, 8'h01);
        check("rst_mode", 8'(bus.cur_mode), 8'h00);
        check("rst_step", 8'(bus.step), 8'h00);
        check("rst_ack", 8'(bus.mode_ack), 8'h00);
        rst    = 1'b0;
        bus.en = 1'b1;

        // ROT_L free run from reset
        for (int k = 0; k < 8; k++) begin
            run_tick("rotl", rotl_seq[k]);
            check("rotl_mode", 8'(bus.cur_mode), 8'h00);
        end

        // BOUNCE: full period plus the turn at 01
        request(2'd2);
        check("bnc_ack", 8'(bus.mode_ack), 8'h01);
        check("bnc_init", bus.led, 8'h01);
        check("bnc_mode", 8'(bus.cur_mode), 8'h02);
        check("bnc_req_step", 8'(bus.step), 8'h00);
        for (int k = 0; k < 15; k++) run_tick("bounce", bounce_seq[k]);
        check("bnc_ack_gone", 8'(bus.mode_ack), 8'h00);

        // FILL
        request(2'd3);
        check("fill_ack", 8'(bus.mode_ack), 8'h01);
        check("fill_init", bus.led, 8'h01);
        for (int k = 0; k < 9; k++) run_tick("fill", fill_seq[k]);

        // ROT_R, freeze at cnt=2 with led=20
        request(2'd1);
        check("rotr_init", bus.led, 8'h80);
        run_tick("rotr", 8'h40);
        run_tick("rotr", 8'h20);
        cycle(2);
        check("pre_freeze_step", 8'(bus.step), 8'h00);
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            check("frz_led", bus.led, 8'h20);
            check("frz_step", 8'(bus.step), 8'h00);
        end
        bus.en = 1'b1;
        cycle(1);
        check("resume_step0", 8'(bus.step), 8'h00);
        check("resume_led0", bus.led, 8'h20);
        cycle(1);
        check("resume_step", 8'(bus.step), 8'h01);
        check("resume_led", bus.led, 8'h10);

        // ROT_L to 08, then request ROT_R in the tick cycle
        request(2'd0);
        check("rotl2_init", bus.led, 8'h01);
        run_tick("rotl2", 8'h02);
        run_tick("rotl2", 8'h04);
        run_tick("rotl2", 8'h08);
        cycle(3);
        request(2'd1);
        check("col_led", bus.led, 8'h80);
        check("col_ack", 8'(bus.mode_ack), 8'h01);
        check("col_step", 8'(bus.step), 8'h00);
        check("col_mode", 8'(bus.cur_mode), 8'h01);
        run_tick("col_next", 8'h40);

        // Back-to-back requests, last wins, each acknowledged
        bus.mode_req = 1'b1;
        bus.mode     = 2'd2;
        cycle(1);
        check("b2b_ack1", 8'(bus.mode_ack), 8'h01);
        check("b2b_mode1", 8'(bus.cur_mode), 8'h02);
        bus.mode = 2'd3;
        cycle(1);
        bus.mode_req = 1'b0;
        check("b2b_ack2", 8'(bus.mode_ack), 8'h01);
        check("b2b_mode2", 8'(bus.cur_mode), 8'h03);
        check("b2b_led", bus.led, 8'h01);
        run_tick("b2b_fill", 8'h03);
        run_tick("b2b_fill", 8'h07);

        // Re-request of the current mode reloads it
        request(2'd3);
        check("rereq_led", bus.led, 8'h01);
        check("rereq_ack", 8'(bus.mode_ack), 8'h01);

        // Request honoured while disabled; pattern then stays put
        bus.en = 1'b0;
        request(2'd1);
        check("dis_req_led", bus.led, 8'h80);
        check("dis_req_ack", 8'(bus.mode_ack), 8'h01);
        cycle(6);
        check("dis_hold_led", bus.led, 8'h80);
        bus.en = 1'b1;
        run_tick("dis_resume", 8'h40);

        // Reset beats a simultaneous request mid-sequence
        cycle(1);
        rst          = 1'b1;
        bus.mode_req = 1'b1;
        bus.mode     = 2'd3;
        cycle(1);
        rst          = 1'b0;
        bus.mode_req = 1'b0;
        check("rst2_led", bus.led, 8'h01);
        check("rst2_mode", 8'(bus.cur_mode), 8'h00);
        check("rst2_ack", 8'(bus.mode_ack), 8'h00);
        check("rst2_step", 8'(bus.step), 8'h00);
        run_tick("post_rst", 8'h02);
        run_tick("post_rst", 8'h04);
        check("post_rst_mode", 8'(bus.cur_mode), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
